tdc_result_capture: RTL and testbench

TDC_RESULT_CAPTURE -- requirements
Module: tdc_result_capture

---
 rtl/tdc_pkg.sv | 26 ++
 rtl/tdc_result_fifo.sv | 82 ++++++++
 rtl/tdc_result_capture.sv | 111 +++++++++++
 tb/tb_tdc_result_capture.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdc_pkg
// Description : Shared widths and the packed result-entry type for the TDC
//               result capture block. The timestamp field exists only when
//               TDC_CAPTURE_TIMESTAMP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package tdc_pkg;

  localparam int COARSE_W = 32;
  localparam int FINE_W   = 9;
  localparam int TS_W     = 16;

  // One stored measurement; field order is fixed so entries pack identically
  // on both sides of the FIFO.
  typedef struct packed {
    logic [COARSE_W-1:0] coarse;
    logic [FINE_W-1:0]   fine;
`ifdef TDC_CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0]     timestamp;
`endif
  } tdc_entry_t;

endpackage : tdc_pkg
`default_nettype wire

// File: rtl/tdc_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tdc_result_fifo
// Description : Show-ahead result storage with wrap-around pointers and an
//               occupancy count. A write while full is accepted only when a
//               read retires the head on the same edge. The head entry reads
//               as all-zero whenever the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_result_fifo
  import tdc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  tdc_entry_t       wr_data,
  input  logic             rd_en,
  output tdc_entry_t       rd_data,
  output logic             valid,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int               PTR_W     = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  tdc_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt;
  logic             valid_r;
  logic             rd_do;
  logic             wr_do;

  // A read only retires an entry that exists; a write needs a free slot or a
  // slot being freed by a read on the same edge.
  assign rd_do = rd_en & valid_r;
  assign wr_do = wr_en & ((count_r != DEPTH_CNT) | rd_do);

  // Next occupancy: simultaneous read and write cancel out.
  always_comb begin
    count_nxt = count_r;
    unique case ({wr_do, rd_do})
      2'b10:   count_nxt = count_r + CNT_ONE;
      2'b01:   count_nxt = count_r - CNT_ONE;
      default: count_nxt = count_r;
    endcase
  end

  // Pointer, count and valid registers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
      valid_r <= 1'b0;
    end else begin
      if (wr_do) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_do) rd_ptr <= rd_ptr + PTR_ONE;
      count_r <= count_nxt;
      valid_r <= (count_nxt != '0);
    end
  end

  // Storage array; contents are never reset and are masked while empty.
  always_ff @(posedge clk) begin
    if (wr_do) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = valid_r ? mem[rd_ptr] : '0;
  assign valid   = valid_r;
  assign full    = (count_r == DEPTH_CNT);
  assign count   = count_r;

endmodule : tdc_result_fifo
`default_nettype wire

// File: rtl/tdc_result_capture.sv
`default_nettype none
// ============================================================================
// Module      : tdc_result_capture
// Description : Captures TDC coarse/fine results on each falling edge of the
//               measurement busy flag into a small show-ahead FIFO read by
//               the SPI register side. Dropped results raise a sticky
//               overflow flag. Defining TDC_CAPTURE_TIMESTAMP_EN adds a
//               16-bit free-running timestamp stored with every entry and
//               the rd_timestamp output port.
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_result_capture
  import tdc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                busy,
  input  logic [COARSE_W-1:0] coarse_result,
  input  logic [FINE_W-1:0]   fine_result,
  input  logic                pop,
  input  logic                clr_ovf,
  output logic [COARSE_W-1:0] rd_coarse,
  output logic [FINE_W-1:0]   rd_fine,
  output logic                valid,
  output logic [CNT_W-1:0]    count,
  output logic                overflow
`ifdef TDC_CAPTURE_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]     rd_timestamp
`endif
);

  // Reject unsupported depths at elaboration.
  if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("tdc_result_capture: DEPTH must be a power of 2 in 2..16");
  end

  logic       busy_q;
  logic       capture;
  logic       drop;
  logic       fifo_full;
  logic       overflow_r;
  tdc_entry_t wr_entry;
  tdc_entry_t rd_entry;

  // Delayed busy for falling-edge detection; reset clears it so a fall right
  // after reset release is not mistaken for the end of a measurement.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= 1'b0;
    else     busy_q <= busy;
  end

  assign capture = busy_q & ~busy;

  // A capture is lost only when storage is full and no pop frees a slot.
  assign drop = capture & fifo_full & ~pop;

  // Sticky overflow; a new drop outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)          overflow_r <= 1'b0;
    else if (drop)    overflow_r <= 1'b1;
    else if (clr_ovf) overflow_r <= 1'b0;
  end

`ifdef TDC_CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;

  // Free-running timestamp; wraps from all-ones to zero.
  always_ff @(posedge clk) begin
    if (rst) ts_cnt <= '0;
    else     ts_cnt <= ts_cnt + TS_W'(1);
  end
`endif

  // Assemble the entry written on a capture edge.
  always_comb begin
    wr_entry        = '0;
    wr_entry.coarse = coarse_result;
    wr_entry.fine   = fine_result;
`ifdef TDC_CAPTURE_TIMESTAMP_EN
    wr_entry.timestamp = ts_cnt;
`endif
  end

  tdc_result_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (capture),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (rd_entry),
    .valid   (valid),
    .full    (fifo_full),
    .count   (count)
  );

  assign rd_coarse = rd_entry.coarse;
  assign rd_fine   = rd_entry.fine;
  assign overflow  = overflow_r;
`ifdef TDC_CAPTURE_TIMESTAMP_EN
  assign rd_timestamp = rd_entry.timestamp;
`endif

endmodule : tdc_result_capture
`default_nettype wire

// File: tb/tb_tdc_result_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdc_result_capture
// Description : Directed scoreboard bench for tdc_result_capture (DEPTH=4).
//               Stimulus pushes expected head entries; a negedge monitor
//               compares the head whenever a pop consumes it. Timestamp
//               checks are built when TDC_CAPTURE_TIMESTAMP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdc_result_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [31:0] coarse_result;
  logic [8:0]  fine_result;
  logic        pop;
  logic        clr_ovf;
  logic [31:0] rd_coarse;
  logic [8:0]  rd_fine;
  logic        valid;
  logic [2:0]  count;
  logic        overflow;
`ifdef TDC_CAPTURE_TIMESTAMP_EN
  logic [15:0] rd_timestamp;
  logic [15:0] tb_ts;
`endif

  typedef struct {
    logic [31:0] c;
    logic [8:0]  f;
    logic [15:0] t;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tdc_result_capture #(.DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .busy          (busy),
    .coarse_result (coarse_result),
    .fine_result   (fine_result),
    .pop           (pop),
    .clr_ovf       (clr_ovf),
    .rd_coarse     (rd_coarse),
    .rd_fine       (rd_fine),
    .valid         (valid),
    .count         (count),
    .overflow      (overflow)
`ifdef TDC_CAPTURE_TIMESTAMP_EN
    ,
    .rd_timestamp  (rd_timestamp)
`endif
  );

`ifdef TDC_CAPTURE_TIMESTAMP_EN
  // Reference free-running counter.
  always @(posedge clk) begin
    if (rst) tb_ts <= 16'h0;
    else     tb_ts <= tb_ts + 16'h1;
  end
`endif

  // Monitor: whenever a pop consumes a valid head, compare it with the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && pop && valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: DUT head coarse=0x%0h fine=0x%0h, no entry expected", rd_coarse, rd_fine);
      end else begin
        e = sb.pop_front();
        if (rd_coarse !== e.c || rd_fine !== e.f
`ifdef TDC_CAPTURE_TIMESTAMP_EN
            || rd_timestamp !== e.t
`endif
           ) begin
          errors++;
`ifdef TDC_CAPTURE_TIMESTAMP_EN
          $display("FAIL head_entry: got coarse=0x%0h fine=0x%0h ts=0x%0h, expected coarse=0x%0h fine=0x%0h ts=0x%0h",
                   rd_coarse, rd_fine, rd_timestamp, e.c, e.f, e.t);
`else
          $display("FAIL head_entry: got coarse=0x%0h fine=0x%0h, expected coarse=0x%0h fine=0x%0h",
                   rd_coarse, rd_fine, e.c, e.f);
`endif
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One measurement: busy high for a cycle, then falls with the result presented.
  task automatic do_capture(input logic [31:0] c, input logic [8:0] f,
                            input bit stored, input bit with_pop);
    exp_t e;
    busy = 1'b1;
    step();
    busy          = 1'b0;
    coarse_result = c;
    fine_result   = f;
    pop           = with_pop;
    if (stored) begin
      e.c = c;
      e.f = f;
      e.t = 16'h0;
`ifdef TDC_CAPTURE_TIMESTAMP_EN
      e.t = tb_ts;
`endif
      sb.push_back(e);
    end
    step();
    pop           = 1'b0;
    coarse_result = 32'hFFFF_FFFF;
    fine_result   = 9'h1FF;
  endtask

  task automatic do_pop();
    pop = 1'b1;
    step();
    pop = 1'b0;
  endtask

  initial begin
`ifdef TDC_CAPTURE_TIMESTAMP_EN
    logic [15:0] ts_a;
`endif
    rst = 1'b1; busy = 1'b0; coarse_result = '0; fine_result = '0;
    pop = 1'b0; clr_ovf = 1'b0;
    repeat (3) step();
    check("reset_count",    64'(count),     64'd0);
    check("reset_valid",    64'(valid),     64'd0);
    check("reset_overflow", 64'(overflow),  64'd0);
    check("reset_rd_coarse",64'(rd_coarse), 64'd0);
    check("reset_rd_fine",  64'(rd_fine),   64'd0);
    rst = 1'b0;
    step();

    // Single capture, 1-cycle latency to valid.
    do_capture(32'h0000_0123, 9'h05A, 1'b1, 1'b0);
    check("t1_valid",  64'(valid),     64'd1);
    check("t1_count",  64'(count),     64'd1);
    check("t1_coarse", 64'(rd_coarse), 64'h123);
    check("t1_fine",   64'(rd_fine),   64'h05A);
    do_pop();
    check("t1_empty_valid",  64'(valid),     64'd0);
    check("t1_empty_coarse", 64'(rd_coarse), 64'd0);
    check("t1_empty_fine",   64'(rd_fine),   64'd0);

    // Five captures into four slots: the fifth is dropped.
    for (int i = 1; i <= 5; i++) do_capture(32'(i), 9'(i * 3), (i <= 4), 1'b0);
    check("t2_count",    64'(count),    64'd4);
    check("t2_overflow", 64'(overflow), 64'd1);
    repeat (4) do_pop();
    check("t2_valid",     64'(valid),     64'd0);
    check("t2_count0",    64'(count),     64'd0);
    check("t2_coarse0",   64'(rd_coarse), 64'd0);
    check("t2_fine0",     64'(rd_fine),   64'd0);
    check("t2_ovf_stick", 64'(overflow),  64'd1);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    check("t2_ovf_clear", 64'(overflow),  64'd0);

    // Full, then capture and pop together: no drop, count holds.
    for (int i = 1; i <= 4; i++) do_capture(32'(i), 9'(i + 100), 1'b1, 1'b0);
    do_capture(32'h0000_0077, 9'h1C3, 1'b1, 1'b1);
    check("t3_count",    64'(count),    64'd4);
    check("t3_overflow", 64'(overflow), 64'd0);
    repeat (4) do_pop();
    check("t3_count0",   64'(count),    64'd0);

    // Pop on empty is ignored; busy levels alone never capture.
    do_pop();
    check("t4_pop_empty_count", 64'(count), 64'd0);
    check("t4_pop_empty_valid", 64'(valid), 64'd0);
    busy = 1'b0; repeat (4) step();
    check("t4_held_low", 64'(count), 64'd0);
    busy = 1'b1; repeat (4) step();
    check("t4_held_high", 64'(count), 64'd0);
    do_capture(32'hCAFE_0001, 9'h011, 1'b1, 1'b0);
    check("t4_one_capture", 64'(count), 64'd1);
    repeat (3) step();
    check("t4_no_repeat", 64'(count), 64'd1);
    for (int i = 2; i <= 4; i++) do_capture(32'hCAFE_0000 + 32'(i), 9'(i), 1'b1, 1'b0);
    check("t4_full", 64'(count), 64'd4);
    busy = 1'b1; step();
    busy = 1'b0; clr_ovf = 1'b1; coarse_result = 32'hDEAD_BEEF; step();
    clr_ovf = 1'b0;
    check("t4_set_wins",   64'(overflow), 64'd1);
    check("t4_drop_count", 64'(count),    64'd4);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    check("t4_clr_only", 64'(overflow), 64'd0);
    do_pop();
    check("t4_count3", 64'(count), 64'd3);

    // Reset mid-measurement with three entries held.
    busy = 1'b1; step();
    rst = 1'b1; step();
    sb.delete();
    check("t5_rst_count", 64'(count), 64'd0);
    check("t5_rst_valid", 64'(valid), 64'd0);
    rst = 1'b0; busy = 1'b0; coarse_result = 32'h0000_0BAD; step();
    check("t5_no_capture_count", 64'(count), 64'd0);
    step();
    check("t5_no_capture_valid", 64'(valid), 64'd0);

`ifdef TDC_CAPTURE_TIMESTAMP_EN
    // Captures ten cycles apart after reset.
    rst = 1'b1; repeat (2) step(); rst = 1'b0;
    check("ts_reset_out", 64'(rd_timestamp), 64'd0);
    do_capture(32'hA, 9'h0A, 1'b1, 1'b0);
    repeat (8) step();
    do_capture(32'hB, 9'h0B, 1'b1, 1'b0);
    ts_a = rd_timestamp;
    do_pop();
    check("ts_delta10", 64'(rd_timestamp - ts_a), 64'd10);
    do_pop();
    check("ts_empty_zero", 64'(rd_timestamp), 64'd0);
    // Captures straddling the counter wrap.
    for (int n = 0; n < 70000 && tb_ts != 16'hFFFD; n++) step();
    for (int i = 0; i < 3; i++) do_capture(32'h100 + 32'(i), 9'(i), 1'b1, 1'b0);
    repeat (3) do_pop();
`endif

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_tdc_result_capture
`default_nettype wire
